// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared helpers and op encoding for the pipelined adder/subtractor
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int seg_width(input int n, input int stages);
    return (n + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/adder_seg.sv
// rtl/adder_seg.sv - combinational W-bit carry segment used by each pipeline stage
module adder_seg #(
  parameter int W = 5
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe_nbit.sv
// rtl/adder_pipe_nbit.sv - STAGES-deep pipelined N-bit adder/subtractor with valid/ready; ADDER_PIPE_OVF_EN adds signed overflow output ovf
module adder_pipe_nbit
  import adder_pkg::*;
#(
  parameter int N      = 10,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N:0]   sum,
  output logic         out_valid,
`ifdef ADDER_PIPE_OVF_EN
  output logic         ovf,
`endif
  input  logic         out_ready
);

  localparam int W = seg_width(N, STAGES);

  logic [STAGES-1:0]        vld_q;
  logic [STAGES-1:0]        op_q;
  logic [STAGES-1:0]        carry_q;
  logic [STAGES-1:0]        carry_d;
  logic [STAGES-1:0][N-1:0] a_q;
  logic [STAGES-1:0][N-1:0] bp_q;
  logic [STAGES-1:0][N-1:0] res_q;
  logic [STAGES-1:0][N-1:0] res_d;
  logic [N-1:0]             bp_in;
  logic                     unused_skew;

  assign bp_in = (sub == OP_SUB) ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * W;
    localparam int HI = (LO + W > N) ? N - 1 : LO + W - 1;

    logic [N-1:0] src_res;
    logic         src_c;

    if (k == 0) begin : g_head
      assign src_res = '0;
      assign src_c   = (sub == OP_SUB);
    end else begin : g_body
      assign src_res = res_q[k-1];
      assign src_c   = carry_q[k-1];
    end

    if (LO < N) begin : g_seg
      localparam int           SW   = HI - LO + 1;
      localparam logic [N-1:0] ONES = '1;
      localparam logic [N-1:0] MASK = (ONES >> (N - SW)) << LO;

      logic [SW-1:0] x;
      logic [SW-1:0] y;
      logic [SW-1:0] s;
      logic          cout;

      if (k == 0) begin : g_in
        assign x = a[HI:LO];
        assign y = bp_in[HI:LO];
      end else begin : g_skew
        assign x = a_q[k-1][HI:LO];
        assign y = bp_q[k-1][HI:LO];
      end

      adder_seg #(.W(SW)) u_seg (
        .x    (x),
        .y    (y),
        .cin  (src_c),
        .s    (s),
        .cout (cout)
      );

      assign res_d[k]   = (src_res & ~MASK) | (N'(s) << LO);
      assign carry_d[k] = cout;
    end else begin : g_pass
      // Segment lies wholly above N: nothing to add, carry rides through.
      assign res_d[k]   = src_res;
      assign carry_d[k] = src_c;
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign in_ready  = !(out_valid && !out_ready);
  assign sum       = {carry_q[STAGES-1] ^ op_q[STAGES-1], res_q[STAGES-1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      op_q    <= '0;
      carry_q <= '0;
      a_q     <= '0;
      bp_q    <= '0;
      res_q   <= '0;
    end else if (in_ready) begin
      for (int k = 0; k < STAGES; k++) begin
        if (k == 0) begin
          vld_q[0] <= in_valid;
          op_q[0]  <= sub;
          a_q[0]   <= a;
          bp_q[0]  <= bp_in;
        end else begin
          vld_q[k] <= vld_q[k-1];
          op_q[k]  <= op_q[k-1];
          a_q[k]   <= a_q[k-1];
          bp_q[k]  <= bp_q[k-1];
        end
        res_q[k]   <= res_d[k];
        carry_q[k] <= carry_d[k];
      end
    end
  end

`ifdef ADDER_PIPE_OVF_EN
  // With B' = ~B for subtract, both cases reduce to: same-sign operands, result sign differs.
  assign ovf = (a_q[STAGES-1][N-1] == bp_q[STAGES-1][N-1]) &&
               (res_q[STAGES-1][N-1] != a_q[STAGES-1][N-1]);
`endif

  assign unused_skew = ^{a_q, bp_q};

endmodule
